// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory slave port between the instruction
// bus and the data bus. The grant is round-robin when both buses request at
// once, and only one transaction is in flight at a time. A watchdog ends a
// transaction with an error if the slave does not answer in time. Every
// output is driven straight from a register.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MASK_W  = 4,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    // instruction bus
    input  logic              i_req,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [MASK_W-1:0] i_mask,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    output logic              i_err,
    // data bus
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [MASK_W-1:0] d_mask,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              d_err,
    // memory slave
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [MASK_W-1:0] mem_mask,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    // The counter only has to reach TIMEOUT-1.
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    state_e             state_q, state_d;
    // The owner of the current transaction doubles as last_grant. Both are
    // written only on a grant, and both get the same value there.
    owner_e             owner_q, owner_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               mem_req_q, mem_req_d;
    logic               mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
    logic [MASK_W-1:0]  mem_mask_q, mem_mask_d;

    logic               i_ready_q, i_ready_d;
    logic               i_err_q, i_err_d;
    logic [DATA_W-1:0]  i_rdata_q, i_rdata_d;
    logic               d_ready_q, d_ready_d;
    logic               d_err_q, d_err_d;
    logic [DATA_W-1:0]  d_rdata_q, d_rdata_d;

    logic               grant_any;
    logic               grant_dbus;
    logic               expire;
    logic               done;
    logic [DATA_W-1:0]  resp_rdata;

    assign grant_any  = i_req | d_req;
    // On a tie the grant goes to dbus when ibus won last time.
    assign grant_dbus = d_req & (~i_req | (owner_q == OWN_I));
    assign expire     = (cnt_q == CNT_W'(TIMEOUT - 1));
    assign done       = mem_ready | expire;
    // A slave answer wins over expiry. A write or a timeout returns zero data.
    assign resp_rdata = (mem_ready && !mem_we_q) ? mem_rdata : '0;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (grant_any) state_d = ST_BUSY;
            ST_BUSY: if (done)      state_d = ST_RESP;
            ST_RESP:                state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    // Next values of the output and datapath registers
    always_comb begin
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_mask_d  = mem_mask_q;
        i_ready_d   = 1'b0;
        i_err_d     = 1'b0;
        i_rdata_d   = '0;
        d_ready_d   = 1'b0;
        d_err_d     = 1'b0;
        d_rdata_d   = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (grant_any) begin
                    mem_req_d = 1'b1;
                    cnt_d     = '0;
                    if (grant_dbus) begin
                        owner_d     = OWN_D;
                        mem_we_d    = d_we;
                        mem_addr_d  = d_addr;
                        mem_wdata_d = d_wdata;
                        mem_mask_d  = d_mask;
                    end else begin
                        owner_d     = OWN_I;
                        mem_we_d    = i_we;
                        mem_addr_d  = i_addr;
                        mem_wdata_d = i_wdata;
                        mem_mask_d  = i_mask;
                    end
                end
            end
            ST_BUSY: begin
                if (done) begin
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = '0;
                    mem_wdata_d = '0;
                    mem_mask_d  = '0;
                    if (owner_q == OWN_D) begin
                        d_ready_d = 1'b1;
                        d_err_d   = ~mem_ready;
                        d_rdata_d = resp_rdata;
                    end else begin
                        i_ready_d = 1'b1;
                        i_err_d   = ~mem_ready;
                        i_rdata_d = resp_rdata;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    // Output and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_q     <= OWN_I;
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_mask_q  <= '0;
            i_ready_q   <= 1'b0;
            i_err_q     <= 1'b0;
            i_rdata_q   <= '0;
            d_ready_q   <= 1'b0;
            d_err_q     <= 1'b0;
            d_rdata_q   <= '0;
        end else begin
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_mask_q  <= mem_mask_d;
            i_ready_q   <= i_ready_d;
            i_err_q     <= i_err_d;
            i_rdata_q   <= i_rdata_d;
            d_ready_q   <= d_ready_d;
            d_err_q     <= d_err_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_mask  = mem_mask_q;
    assign i_ready   = i_ready_q;
    assign i_err     = i_err_q;
    assign i_rdata   = i_rdata_q;
    assign d_ready   = d_ready_q;
    assign d_err     = d_err_q;
    assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. The main instance uses the default
// watchdog (255 cycles). A second instance with TIMEOUT=4 shares the same
// inputs and is checked only in the watchdog scenarios.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, i_we, d_req, d_we, mem_ready;
    logic [31:0] i_addr, i_wdata, d_addr, d_wdata, mem_rdata;
    logic [3:0]  i_mask, d_mask;

    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
    logic        i_ready, i_err, d_ready, d_err, mem_req, mem_we;
    logic [3:0]  mem_mask;

    logic [31:0] t_i_rdata, t_d_rdata, t_mem_addr, t_mem_wdata;
    logic        t_i_ready, t_i_err, t_d_ready, t_d_err, t_mem_req, t_mem_we;
    logic [3:0]  t_mem_mask;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MASK_W(4), .TIMEOUT(255)) u_dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_we(i_we), .i_addr(i_addr), .i_wdata(i_wdata), .i_mask(i_mask),
        .i_rdata(i_rdata), .i_ready(i_ready), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_mask(d_mask),
        .d_rdata(d_rdata), .d_ready(d_ready), .d_err(d_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_mask(mem_mask), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MASK_W(4), .TIMEOUT(4)) u_dut_to (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_we(i_we), .i_addr(i_addr), .i_wdata(i_wdata), .i_mask(i_mask),
        .i_rdata(t_i_rdata), .i_ready(t_i_ready), .i_err(t_i_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_mask(d_mask),
        .d_rdata(t_d_rdata), .d_ready(t_d_ready), .d_err(t_d_err),
        .mem_req(t_mem_req), .mem_we(t_mem_we), .mem_addr(t_mem_addr), .mem_wdata(t_mem_wdata),
        .mem_mask(t_mem_mask), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    task automatic clear_inputs();
        i_req = 0; i_we = 0; i_addr = '0; i_wdata = '0; i_mask = '0;
        d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_mask = '0;
        mem_ready = 0; mem_rdata = '0;
    endtask

    // Ends on a falling edge with reset released.
    task automatic apply_reset();
        @(negedge clk);
        rst = 0;
        clear_inputs();
        repeat (2) @(negedge clk);
        rst = 1;
    endtask

    task automatic test_reset();
        rst = 0;
        clear_inputs();
        repeat (2) @(negedge clk);
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %b expected 0", mem_req); end
        n_checks++; if ({mem_we, mem_addr, mem_wdata, mem_mask} !== 69'd0) begin n_fail++; $display("FAIL reset_mem_payload: got %h expected 0", {mem_we, mem_addr, mem_wdata, mem_mask}); end
        n_checks++; if ({i_ready, i_err, i_rdata} !== 34'd0) begin n_fail++; $display("FAIL reset_ibus_resp: got %h expected 0", {i_ready, i_err, i_rdata}); end
        n_checks++; if ({d_ready, d_err, d_rdata} !== 34'd0) begin n_fail++; $display("FAIL reset_dbus_resp: got %h expected 0", {d_ready, d_err, d_rdata}); end
        rst = 1;
        // A stray mem_ready while IDLE must be ignored.
        mem_ready = 1; mem_rdata = 32'h1111_2222;
        @(negedge clk);
        mem_ready = 0; mem_rdata = '0;
        @(negedge clk);
        n_checks++; if ({mem_req, i_ready, d_ready} !== 3'b000) begin n_fail++; $display("FAIL idle_ready_ignored: got %b expected 000", {mem_req, i_ready, d_ready}); end
    endtask

    task automatic test_single_ibus_read();
        apply_reset();
        i_req = 1; i_we = 0; i_addr = 32'h8000_0000; i_mask = 4'hF;
        @(negedge clk);
        n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL single_mem_req: got %b expected 1", mem_req); end
        n_checks++; if (mem_addr !== 32'h8000_0000) begin n_fail++; $display("FAIL single_mem_addr: got %h expected 80000000", mem_addr); end
        n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL single_mem_we: got %b expected 0", mem_we); end
        mem_ready = 1; mem_rdata = 32'h0000_0413;
        @(negedge clk);
        n_checks++; if ({i_ready, i_err} !== 2'b10) begin n_fail++; $display("FAIL single_i_ready_err: got %b expected 10", {i_ready, i_err}); end
        n_checks++; if (i_rdata !== 32'h0000_0413) begin n_fail++; $display("FAIL single_i_rdata: got %h expected 00000413", i_rdata); end
        n_checks++; if ({d_ready, d_rdata} !== 33'd0) begin n_fail++; $display("FAIL single_d_quiet: got %h expected 0", {d_ready, d_rdata}); end
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL single_mem_req_drop: got %b expected 0", mem_req); end
        mem_ready = 0; mem_rdata = '0; i_req = 0;
        @(negedge clk);
        n_checks++; if ({i_ready, i_rdata} !== 33'd0) begin n_fail++; $display("FAIL single_ready_pulse: got %h expected 0", {i_ready, i_rdata}); end
    endtask

    task automatic test_simultaneous();
        apply_reset();
        i_req = 1; i_we = 0; i_addr = 32'h0000_0200; i_mask = 4'hF;
        d_req = 1; d_we = 1; d_addr = 32'h0000_0100; d_wdata = 32'hDEAD_BEEF; d_mask = 4'hF;
        @(negedge clk);
        n_checks++; if ({mem_req, mem_we} !== 2'b11) begin n_fail++; $display("FAIL simul_d_first_req_we: got %b expected 11", {mem_req, mem_we}); end
        n_checks++; if (mem_addr !== 32'h0000_0100) begin n_fail++; $display("FAIL simul_d_first_addr: got %h expected 00000100", mem_addr); end
        n_checks++; if ({mem_wdata, mem_mask} !== {32'hDEAD_BEEF, 4'hF}) begin n_fail++; $display("FAIL simul_wdata_mask: got %h expected deadbeeff", {mem_wdata, mem_mask}); end
        mem_ready = 1; mem_rdata = 32'h5555_5555;
        @(negedge clk);
        n_checks++; if ({d_ready, d_err, i_ready} !== 3'b100) begin n_fail++; $display("FAIL simul_d_ready: got %b expected 100", {d_ready, d_err, i_ready}); end
        n_checks++; if (d_rdata !== 32'd0) begin n_fail++; $display("FAIL simul_write_rdata_zero: got %h expected 0", d_rdata); end
        mem_ready = 0; mem_rdata = '0; d_req = 0;
        @(negedge clk);
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL simul_idle_gap: got %b expected 0", mem_req); end
        @(negedge clk);
        n_checks++; if ({mem_req, mem_we, mem_addr} !== {2'b10, 32'h0000_0200}) begin n_fail++; $display("FAIL simul_i_second: got %h expected 200000200", {mem_req, mem_we, mem_addr}); end
        mem_ready = 1; mem_rdata = 32'h0000_1234;
        @(negedge clk);
        n_checks++; if ({i_ready, i_err, d_ready, i_rdata} !== {3'b100, 32'h0000_1234}) begin n_fail++; $display("FAIL simul_i_done: got %h expected 400001234", {i_ready, i_err, d_ready, i_rdata}); end
        mem_ready = 0; mem_rdata = '0; i_req = 0;
    endtask

    task automatic test_back_to_back();
        int unsigned i_cnt, d_cnt, w;
        logic [31:0] exp_addr;
        logic [31:0] exp_data;
        logic [1:0]  exp_rdy;
        i_cnt = 0; d_cnt = 0;
        apply_reset();
        i_req = 1; i_we = 0; i_addr = 32'h0000_1000; i_mask = 4'hF;
        d_req = 1; d_we = 0; d_addr = 32'h0000_2000; d_mask = 4'hF;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            w = 0;
            while (mem_req !== 1'b1 && w < 6) begin
                @(negedge clk);
                w++;
            end
            exp_addr = (k % 2 == 0) ? 32'h0000_2000 : 32'h0000_1000;
            exp_rdy  = (k % 2 == 0) ? 2'b10 : 2'b01;
            exp_data = 32'hC0DE_0000 + 32'(k);
            n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL b2b_grant_wait[%0d]: got mem_req=%b expected 1 within 6 cycles", k, mem_req); end
            n_checks++; if (mem_addr !== exp_addr) begin n_fail++; $display("FAIL b2b_grant_order[%0d]: got %h expected %h", k, mem_addr, exp_addr); end
            mem_ready = 1; mem_rdata = exp_data;
            @(negedge clk);
            mem_ready = 0; mem_rdata = '0;
            n_checks++; if ({d_ready, i_ready} !== exp_rdy) begin n_fail++; $display("FAIL b2b_ready[%0d]: got %b expected %b", k, {d_ready, i_ready}, exp_rdy); end
            n_checks++; if ((d_ready ? d_rdata : i_rdata) !== exp_data) begin n_fail++; $display("FAIL b2b_rdata[%0d]: got %h expected %h", k, (d_ready ? d_rdata : i_rdata), exp_data); end
            if (d_ready === 1'b1) d_cnt++;
            if (i_ready === 1'b1) i_cnt++;
        end
        n_checks++; if (d_cnt != 4) begin n_fail++; $display("FAIL b2b_d_count: got %0d expected 4", d_cnt); end
        n_checks++; if (i_cnt != 4) begin n_fail++; $display("FAIL b2b_i_count: got %0d expected 4", i_cnt); end
        i_req = 0; d_req = 0;
    endtask

    task automatic test_stall();
        int unsigned stable;
        stable = 0;
        apply_reset();
        d_req = 1; d_we = 0; d_addr = 32'h0000_0300; d_mask = 4'h3;
        @(negedge clk);
        for (int c = 1; c <= 10; c++) begin
            if (mem_req === 1'b1 && mem_we === 1'b0 && mem_addr === 32'h0000_0300 &&
                mem_mask === 4'h3 && d_ready === 1'b0) stable++;
            // Input changes during BUSY must not reach mem_*.
            if (c == 5) begin d_addr = 32'h0000_0999; d_we = 1; d_mask = 4'hC; end
            if (c == 10) begin mem_ready = 1; mem_rdata = 32'h0000_5AA5; end
            @(negedge clk);
        end
        n_checks++; if (stable != 10) begin n_fail++; $display("FAIL stall_stable_cycles: got %0d expected 10", stable); end
        n_checks++; if ({d_ready, d_err, d_rdata} !== {2'b10, 32'h0000_5AA5}) begin n_fail++; $display("FAIL stall_done: got %h expected 200005aa5", {d_ready, d_err, d_rdata}); end
        mem_ready = 0; mem_rdata = '0; d_req = 0;
        @(negedge clk);
        n_checks++; if (d_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready_pulse: got %b expected 0", d_ready); end
    endtask

    task automatic test_timeout();
        int unsigned hi;
        hi = 0;
        apply_reset();
        i_req = 1; i_we = 0; i_addr = 32'h0000_0400; i_mask = 4'hF;
        mem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        for (int c = 1; c <= 4; c++) begin
            if (t_mem_req === 1'b1) hi++;
            @(negedge clk);
        end
        n_checks++; if (hi != 4) begin n_fail++; $display("FAIL timeout_req_cycles: got %0d expected 4", hi); end
        n_checks++; if (t_mem_req !== 1'b0) begin n_fail++; $display("FAIL timeout_req_drop: got %b expected 0", t_mem_req); end
        n_checks++; if ({t_i_ready, t_i_err, t_d_ready} !== 3'b110) begin n_fail++; $display("FAIL timeout_err: got %b expected 110", {t_i_ready, t_i_err, t_d_ready}); end
        n_checks++; if (t_i_rdata !== 32'd0) begin n_fail++; $display("FAIL timeout_rdata_zero: got %h expected 0", t_i_rdata); end
        i_req = 0;
        @(negedge clk);
        n_checks++; if ({t_i_ready, t_i_err} !== 2'b00) begin n_fail++; $display("FAIL timeout_pulse: got %b expected 00", {t_i_ready, t_i_err}); end
        @(negedge clk);
        n_checks++; if (t_mem_req !== 1'b0) begin n_fail++; $display("FAIL timeout_back_idle: got %b expected 0", t_mem_req); end

        // mem_ready in the expiry cycle completes normally.
        apply_reset();
        i_req = 1; i_we = 0; i_addr = 32'h0000_0404; i_mask = 4'hF;
        mem_rdata = 32'h0000_ABCD;
        @(negedge clk);
        for (int c = 1; c <= 4; c++) begin
            if (c == 4) mem_ready = 1;
            @(negedge clk);
        end
        n_checks++; if ({t_i_ready, t_i_err, t_i_rdata} !== {2'b10, 32'h0000_ABCD}) begin n_fail++; $display("FAIL timeout_ready_wins: got %h expected 20000abcd", {t_i_ready, t_i_err, t_i_rdata}); end
        mem_ready = 0; mem_rdata = '0; i_req = 0;
    endtask

    task automatic test_async_reset();
        apply_reset();
        d_req = 1; d_we = 0; d_addr = 32'h0000_0500; d_mask = 4'hF;
        @(negedge clk);
        n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL areset_busy: got %b expected 1", mem_req); end
        #2 rst = 0;
        #1;
        n_checks++; if ({mem_req, mem_addr} !== 33'd0) begin n_fail++; $display("FAIL areset_immediate: got %h expected 0", {mem_req, mem_addr}); end
        n_checks++; if ({i_ready, i_err, d_ready, d_err} !== 4'b0000) begin n_fail++; $display("FAIL areset_resp_quiet: got %b expected 0000", {i_ready, i_err, d_ready, d_err}); end
        d_req = 0;
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        n_checks++; if ({mem_req, d_ready} !== 2'b00) begin n_fail++; $display("FAIL areset_no_ready: got %b expected 00", {mem_req, d_ready}); end
        d_req = 1; d_addr = 32'h0000_0600;
        @(negedge clk);
        n_checks++; if ({mem_req, mem_addr} !== {1'b1, 32'h0000_0600}) begin n_fail++; $display("FAIL areset_fresh_grant: got %h expected 100000600", {mem_req, mem_addr}); end
        mem_ready = 1; mem_rdata = 32'h0000_0077;
        @(negedge clk);
        n_checks++; if ({d_ready, d_err, d_rdata} !== {2'b10, 32'h0000_0077}) begin n_fail++; $display("FAIL areset_fresh_done: got %h expected 200000077", {d_ready, d_err, d_rdata}); end
        mem_ready = 0; mem_rdata = '0; d_req = 0;
    endtask

    initial begin
        test_reset();
        test_single_ibus_read();
        test_simultaneous();
        test_back_to_back();
        test_stall();
        test_timeout();
        test_async_reset();
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single physical memory port between the core's instruction bus (ibus) and data bus (dbus).
- Sits between the riscv_ic core bus outputs and the memory/DPI slave.
- Adds a req/ready handshake, round-robin arbitration on contention, per-transaction locking, and a watchdog timeout that returns an error to the owning master.

Parameters:
- ADDR_W, 32, address width of both masters and the slave port
- DATA_W, 32, data width
- MASK_W, 4, byte-mask width (DATA_W/8)
- TIMEOUT, 255, max cycles in BUSY waiting for mem_ready before error; must be ≥1

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- i_req  in  1  ibus request, held until i_ready
- i_we  in  1  ibus write enable
- i_addr  in  ADDR_W  ibus address
- i_wdata  in  DATA_W  ibus write data
- i_mask  in  MASK_W  ibus byte mask
- i_rdata  out  DATA_W  ibus read data, valid with i_ready
- i_ready  out  1  ibus completion pulse, 1 cycle
- i_err  out  1  ibus timeout flag, valid with i_ready
- d_req, d_we, d_addr, d_wdata, d_mask  in  1/1/ADDR_W/DATA_W/MASK_W  dbus request, same semantics as ibus
- d_rdata  out  DATA_W  dbus read data
- d_ready  out  1  dbus completion pulse
- d_err  out  1  dbus timeout flag
- mem_req  out  1  slave request, held until mem_ready or timeout
- mem_we  out  1  slave write enable
- mem_addr  out  ADDR_W  slave address
- mem_wdata  out  DATA_W  slave write data
- mem_mask  out  MASK_W  slave byte mask
- mem_rdata  in  DATA_W  slave read data, valid with mem_ready
- mem_ready  in  1  slave completion, 1-cycle pulse

Behaviour:
- Reset (rst=0, async): state=IDLE; all outputs 0; last_grant=IBUS; timeout counter=0.
- All outputs are registered.
- Master rules: req and payload stay stable from assertion until the ready pulse. Req still high in the cycle after ready counts as a new request.
- FSM IDLE:
  - No req: stay in IDLE.
  - One req: grant it.
  - Both req: grant the master not equal to last_grant (round-robin). After reset the first tie goes to dbus.
  - On grant: latch winner's we/addr/wdata/mask into mem_* regs, set mem_req=1, record owner, update last_grant, clear counter, go to BUSY.
- FSM BUSY:
  - mem_* held constant.
  - mem_ready=1: capture mem_rdata (0 on writes), drop mem_req and all mem_* to 0, go to RESP with err=0.
  - Otherwise: counter++. When counter reaches TIMEOUT-1 with no mem_ready, drop mem_req, go to RESP with rdata=0, err=1.
  - mem_ready arriving in the same cycle as expiry wins: normal completion, err=0.
- FSM RESP: pulse owner's ready (and err) for exactly 1 cycle with owner's rdata; go to IDLE.
- The non-owner's ready/err/rdata are 0 in every cycle.
- Latency: req seen in IDLE at cycle 0 → mem_req high in cycle 1 → with mem_ready in cycle 1, owner ready in cycle 2. Minimum 3 cycles per transaction.
- The losing master waits. Its req is not re-sampled until IDLE, so it wins the next IDLE evaluation if the winner does not re-request. If the winner does re-request, round-robin still hands the next grant to the loser.
- mem_ready while IDLE or RESP is ignored.
- Input changes during BUSY do not affect mem_*.
- Reset asserted mid-transaction: immediate return to IDLE, outputs 0, no ready issued.

Test Plan:
- Single ibus read: i_req=1, i_addr=0x8000_0000; slave returns mem_rdata=0x0000_0413 one cycle after mem_req → mem_addr=0x8000_0000 in cycle 1, i_ready=1, i_rdata=0x413, i_err=0 in cycle 2; d_ready stays 0.
- Simultaneous requests from reset: i_req and d_req rise together (dbus write addr 0x100, wdata 0xDEADBEEF, mask 0xF) → dbus granted first, mem_we=1, mem_wdata=0xDEADBEEF; ibus granted next and completes after d_ready.
- Sustained contention: both masters re-request continuously for 8 transactions → grants alternate D,I,D,I…; each master gets exactly 4.
- Slave stall: mem_ready delayed 10 cycles → mem_* stable for 10 cycles, owner ready exactly 1 cycle after the mem_ready cycle.
- Timeout: TIMEOUT=4, mem_ready never asserted → mem_req high 4 cycles then drops; owner gets ready=1, err=1, rdata=0; arbiter returns to IDLE. mem_ready coinciding with expiry → err=0.
- Async reset in BUSY: rst=0 mid-cycle → mem_req, all ready/err drop immediately; after release, a fresh d_req completes normally.
